// File: rtl/inst_fetch_queue.sv
// Instruction buffer between fetch and decode: DEPTH-entry FIFO of {inst, addr}
// with valid/ready on both sides, execute-stage flush (jump) and decode hold.
module inst_fetch_queue #(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [DATA_W-1:0] NOP_INST = DATA_W'(32'h0000_0013)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] inst_i,
  input  logic [ADDR_W-1:0] inst_addr_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic              jump_flag_ex_i,
  input  logic              hold_flag_ex_i,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [DATA_W-1:0] inst;
    logic [ADDR_W-1:0] addr;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic          push_c;
  logic          pop_c;

  // Handshakes and head view are decoded from registered state only
  always_comb begin
    in_ready_o  = (count < CW'(DEPTH));
    out_valid_o = (count != '0);
    push_c      = in_valid_i && in_ready_o && !jump_flag_ex_i;
    pop_c       = out_valid_o && out_ready_i && !hold_flag_ex_i && !jump_flag_ex_i;
    inst_o      = out_valid_o ? mem[rp].inst : NOP_INST;
    inst_addr_o = out_valid_o ? mem[rp].addr : '0;
    count_o     = count;
  end

  always_comb begin
    count_nxt = count;
    case ({push_c, pop_c})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // Pointer/occupancy state; flush discards everything including a same-cycle push
  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else if (jump_flag_ex_i) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push_c) wp <= wp + PW'(1);
      if (pop_c)  rp <= rp + PW'(1);
      count <= count_nxt;
    end
  end

  // Storage needs no reset: entries are only visible while counted
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wp].inst <= inst_i;
      mem[wp].addr <= inst_addr_i;
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Scoreboard bench for inst_fetch_queue: a queue-based reference model tracks
// accepted pairs; a negedge monitor checks head, occupancy and handshakes.
module tb_inst_fetch_queue;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] addr;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_i;
  logic [31:0] inst_addr_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic        jump_flag_ex_i;
  logic        hold_flag_ex_i;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [2:0]  count_o;

  ent_t sb_q[$];
  bit   chk_en = 0;
  int   chk_cnt = 0;
  int   pass_cnt = 0;
  int   pop_cnt = 0;

  inst_fetch_queue #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst),
    .inst_i(inst_i), .inst_addr_i(inst_addr_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .jump_flag_ex_i(jump_flag_ex_i), .hold_flag_ex_i(hold_flag_ex_i),
    .inst_o(inst_o), .inst_addr_o(inst_addr_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .count_o(count_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: accepted pairs are queued, consumed heads are dropped
  initial forever begin
    bit p, q;
    @(posedge clk);
    if (rst) begin
      sb_q.delete();
      chk_en = 1;
    end else if (jump_flag_ex_i) begin
      sb_q.delete();
    end else begin
      p = in_valid_i && (sb_q.size() < DEPTH);
      q = (sb_q.size() != 0) && out_ready_i && !hold_flag_ex_i;
      if (q) begin
        void'(sb_q.pop_front());
        pop_cnt++;
      end
      if (p) sb_q.push_back('{inst_i, inst_addr_i});
    end
  end

  // Monitor: compares DUT outputs against the scoreboard mid-cycle
  initial forever begin
    ent_t head;
    @(negedge clk);
    if (chk_en) begin
      check("count", 64'(count_o), 64'(sb_q.size()));
      check("in_ready", 64'(in_ready_o), 64'(sb_q.size() < DEPTH));
      check("out_valid", 64'(out_valid_o), 64'(sb_q.size() != 0));
      if (sb_q.size() != 0) begin
        head = sb_q[0];
        check("head_inst", 64'(inst_o), 64'(head.inst));
        check("head_addr", 64'(inst_addr_o), 64'(head.addr));
      end else begin
        check("nop_inst", 64'(inst_o), 64'(NOP));
        check("nop_addr", 64'(inst_addr_o), 64'd0);
      end
    end
  end

  task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] a,
                       input logic ordy, input logic hold, input logic jump, input logic r);
    in_valid_i     = v;
    inst_i         = i;
    inst_addr_i    = a;
    out_ready_i    = ordy;
    hold_flag_ex_i = hold;
    jump_flag_ex_i = jump;
    rst            = r;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_drain(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset with valid input asserted
    drive(1'b1, 32'hDEAD, 32'hBEEF, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 32'hDEAD, 32'hBEEF, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_count", 64'(count_o), 64'd0);
    check("rst_inst", 64'(inst_o), 64'(NOP));

    // Fill to full, fifth push ignored, then drain
    for (int k = 0; k < 5; k++)
      drive(1'b1, 32'hA0 + 32'(k), 32'h100 + 32'(4 * k), 1'b0, 1'b0, 1'b0, 1'b0);
    check("full_count", 64'(count_o), 64'd4);
    check("full_ready", 64'(in_ready_o), 64'd0);
    idle_drain(5);
    check("drain_pops", 64'(pop_cnt), 64'd4);

    // Concurrent push/pop at occupancy 2 across pointer wrap
    for (int k = 0; k < 2; k++)
      drive(1'b1, 32'h200 + 32'(k), 32'h2000 + 32'(4 * k), 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 2; k < 12; k++) begin
      drive(1'b1, 32'h200 + 32'(k), 32'h2000 + 32'(4 * k), 1'b1, 1'b0, 1'b0, 1'b0);
      check("stream_count", 64'(count_o), 64'd2);
    end
    idle_drain(3);

    // Hold freezes the head while fetch keeps filling
    for (int k = 0; k < 2; k++)
      drive(1'b1, 32'h300 + 32'(k), 32'h3000 + 32'(4 * k), 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 2; k < 5; k++)
      drive(1'b1, 32'h300 + 32'(k), 32'h3000 + 32'(4 * k), 1'b1, 1'b1, 1'b0, 1'b0);
    check("hold_head", 64'(inst_o), 64'h300);
    check("hold_ready", 64'(in_ready_o), 64'd0);
    idle_drain(5);

    // Flush with a simultaneous push, then a fresh push
    for (int k = 0; k < 3; k++)
      drive(1'b1, 32'h400 + 32'(k), 32'h4000 + 32'(4 * k), 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'hB0, 32'h5000, 1'b1, 1'b1, 1'b1, 1'b0);
    check("flush_valid", 64'(out_valid_o), 64'd0);
    drive(1'b1, 32'hC0, 32'h6000, 1'b0, 1'b0, 1'b0, 1'b0);
    check("post_flush_head", 64'(inst_o), 64'hC0);
    idle_drain(3);

    // Reset mid-stream
    for (int k = 0; k < 3; k++)
      drive(1'b1, 32'h500 + 32'(k), 32'h7000 + 32'(4 * k), 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("midrst_count", 64'(count_o), 64'd0);
    idle_drain(4);

    // Randomised traffic
    for (int k = 0; k < 3000; k++)
      drive($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom_range(0, 2) != 0,
            $urandom_range(0, 5) == 0, $urandom_range(0, 24) == 0, $urandom_range(0, 150) == 0);
    idle_drain(DEPTH + 2);
    check("final_empty", 64'(count_o), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/inst_fetch_queue.md
# inst_fetch_queue

Parametrised instruction buffer between fetch and decode, successor to the single-register fetch/decode pipeline stage. It holds up to DEPTH fetched instruction/address pairs in FIFO order and decouples fetch from decode with valid/ready handshakes on both sides. It also takes the execute-stage jump (flush) and hold controls. Whenever no instruction is presented, decode sees a NOP with address zero.

## Interface
Clock is `clk`; reset is `rst`. Reset is synchronous and active-high, sampled on the rising edge of `clk`.

Parameters:
- DATA_W, 32: instruction width.
- ADDR_W, 32: instruction address width.
- DEPTH, 4: number of entries. Must be a power of two, ≥ 2.
- NOP_INST, 32'h00000013: value driven on `inst_o` when `out_valid_o` = 0 (addi x0,x0,0).

Derived widths:
- PW = $clog2(DEPTH) for the read/write pointers.
- CW = PW+1 for the occupancy count.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- inst_i  in  DATA_W  fetched instruction.
- inst_addr_i  in  ADDR_W  address of `inst_i`.
- in_valid_i  in  1  fetch presents a valid pair.
- in_ready_o  out  1  queue can accept this cycle.
- jump_flag_ex_i  in  1  execute redirect; flushes the queue.
- hold_flag_ex_i  in  1  execute stall; freezes the decode side.
- inst_o  out  DATA_W  head instruction, or NOP_INST.
- inst_addr_o  out  ADDR_W  head address, or 0.
- out_valid_o  out  1  head entry is valid.
- out_ready_i  in  1  decode consumes the head.
- count_o  out  CW  current occupancy, 0..DEPTH.

## Operation
- **Storage and state:** DEPTH-entry register array of {inst, addr}, write pointer `wp`, read pointer `rp` (both PW bits) and `count` (CW bits). The pointers wrap modulo DEPTH naturally.
- **Push/pop conditions:**
  - push = in_valid_i & in_ready_o & !jump_flag_ex_i.
  - pop = out_valid_o & out_ready_i & !hold_flag_ex_i & !jump_flag_ex_i.
- **Handshake outputs:**
  - in_ready_o = (count < DEPTH). It depends only on registered state, with no combinational path from `out_ready_i`.
  - out_valid_o = (count != 0).
- **Data outputs:**
  - inst_o = out_valid_o ? mem[rp].inst : NOP_INST.
  - inst_addr_o = out_valid_o ? mem[rp].addr : 0.
  - count_o = count.
- **Priority, evaluated per edge:**
  1. rst.
  2. jump_flag_ex_i (flush): wp, rp and count are set to 0. Any push in that cycle is dropped. Storage contents are don't-care.
  3. Normal update:
     - push: writes mem[wp] and increments wp.
     - pop: increments rp.
     - count += push − pop. Simultaneous push and pop leaves count unchanged.
- **Hold:**
  - Decode side is frozen: no pop; inst_o, inst_addr_o and out_valid_o stay stable unless a push arrives into an empty queue.
  - Fetch side continues to push until full.
- **Boundary cases:**
  - Full (count = DEPTH): in_ready_o = 0, so in_valid_i is ignored. A pop while full frees a slot that is usable the next cycle, not the same cycle.
  - Empty: pop is impossible; outputs show NOP_INST / 0.
  - Wrap-around: wp and rp wrap DEPTH−1 → 0 with no special handling.
  - Jump and hold together: jump wins (flush).
  - Reset mid-operation: all entries are discarded at that edge. No stale entry may appear afterwards.

## Timing
- **Reset values:** count_o = 0, out_valid_o = 0, in_ready_o = 1, inst_o = NOP_INST, inst_addr_o = 0.
- **Push-to-output latency:** 1 cycle. A pair pushed at edge N is visible on inst_o/out_valid_o after edge N when the queue was empty; there is no same-cycle bypass.
- **Throughput:** sustained 1 push + 1 pop per cycle at any occupancy 1..DEPTH−1.
- **Flush:** takes effect at the edge where jump_flag_ex_i = 1. From the following cycle, out_valid_o = 0 and the outputs show NOP/0. The first post-flush push is visible 1 cycle after it is accepted.
- **Combinational paths:** all outputs are functions of registered state only.

## Test plan
- **Reset:** assert rst for 2 cycles with in_valid_i = 1 → count_o = 0, inst_o = 32'h00000013, inst_addr_o = 0, in_ready_o = 1, out_valid_o = 0.
- **Fill to full:** push 4 pairs (inst 0xA0..0xA3, addr 0x100..0x10C) with out_ready_i = 0 → count_o reaches 4, in_ready_o = 0. A fifth push (0xA4) is ignored. Draining then yields 0xA0..0xA3 in order with matching addresses, and count_o returns to 0.
- **Concurrent push/pop and wrap-around:** with count = 2, push and pop every cycle for 10 cycles → count_o stays 2 throughout. Output order equals push order across pointer wrap, with no duplicate or lost entry.
- **Hold:** with 2 entries queued and hold_flag_ex_i = 1 for 3 cycles, out_ready_i = 1 and pushes continuing → inst_o stays on the head, count rises to 4 and then in_ready_o = 0. After hold is released, pops resume in order.
- **Flush:** with 3 entries queued, assert jump_flag_ex_i for one cycle together with a push of 0xB0 → next cycle count_o = 0, out_valid_o = 0, inst_o = NOP, inst_addr_o = 0, and 0xB0 is absent. A push of 0xC0 one cycle later appears as the head after 1 cycle.
- **Reset mid-stream:** with 3 entries queued, assert rst for 1 cycle → same state as after power-on reset. No pre-reset entry ever reappears.
